// File: rtl/pad_cfg_pkg.sv
// Shared types and field layout for the pad configuration sequencer.
// A pad config word is {mode[1:0], cs, sl, pu, pd}.
package pad_cfg_pkg;

  localparam int CFG_W    = 6;
  localparam int ADDR_W   = 6;
  localparam int PD_BIT   = 0;
  localparam int PU_BIT   = 1;
  localparam int SL_BIT   = 2;
  localparam int CS_BIT   = 3;
  localparam int MODE_LSB = 4;

  typedef enum logic [1:0] {
    MODE_HIZ    = 2'd0,
    MODE_INPUT  = 2'd1,
    MODE_OUTPUT = 2'd2,
    MODE_BIDIR  = 2'd3
  } pad_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_APPLY  = 2'd2
  } seq_state_e;

  localparam logic [CFG_W-1:0] RESET_CFG = 6'b01_0000;

  function automatic logic mode_drives(input pad_mode_e m);
    return (m == MODE_OUTPUT) || (m == MODE_BIDIR);
  endfunction

  // Contradictory pull request is stored as no pull at all.
  function automatic logic [CFG_W-1:0] sanitize_cfg(input logic [CFG_W-1:0] d);
    logic [CFG_W-1:0] r;
    r = d;
    if (d[PU_BIT] && d[PD_BIT]) begin
      r[PU_BIT] = 1'b0;
      r[PD_BIT] = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/pad_cfg_slot.sv
// One bidirectional pad: config register, tristate-force bit and output decode.
module pad_cfg_slot
  import pad_cfg_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [CFG_W-1:0] wr_cfg,
  input  logic             force_set,
  input  logic             func_out,
  input  logic             func_oe,
  output pad_mode_e        mode,
  output logic             pad_out,
  output logic             pad_oe,
  output logic             pad_ie,
  output logic             pad_cs,
  output logic             pad_sl,
  output logic             pad_pu,
  output logic             pad_pd
);

  logic [CFG_W-1:0] cfg_reg;
  logic             force_reg;

  // The force bit is released by the same write that lands the new mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_reg   <= RESET_CFG;
      force_reg <= 1'b0;
    end else begin
      if (wr_en) cfg_reg <= wr_cfg;
      if (force_set)  force_reg <= 1'b1;
      else if (wr_en) force_reg <= 1'b0;
    end
  end

  always_comb begin
    mode    = pad_mode_e'(cfg_reg[MODE_LSB +: 2]);
    pad_cs  = cfg_reg[CS_BIT];
    pad_sl  = cfg_reg[SL_BIT];
    pad_pu  = cfg_reg[PU_BIT];
    pad_pd  = cfg_reg[PD_BIT];
    pad_ie  = (mode != MODE_HIZ);
    pad_out = mode_drives(mode) ? func_out : 1'b0;
    pad_oe  = 1'b0;
    if (!force_reg) begin
      if (mode == MODE_OUTPUT)     pad_oe = 1'b1;
      else if (mode == MODE_BIDIR) pad_oe = func_oe;
    end
  end

endmodule

// File: rtl/pad_cfg_sequencer.sv
// Pad ring configuration owner: accepts config writes and applies them with a
// break-before-make tristate window when a driving pad changes mode.
module pad_cfg_sequencer
  import pad_cfg_pkg::*;
#(
  parameter int NUM_INPUT     = 12,
  parameter int NUM_BIDIR     = 42,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [ADDR_W-1:0]    cfg_addr,
  input  logic [CFG_W-1:0]     cfg_data,
  output logic                 busy,
  output logic                 err,
  input  logic                 err_clr,
  input  logic [NUM_BIDIR-1:0] func_out,
  input  logic [NUM_BIDIR-1:0] func_oe,
  output logic [NUM_BIDIR-1:0] bidir_out,
  output logic [NUM_BIDIR-1:0] bidir_oe,
  output logic [NUM_BIDIR-1:0] bidir_ie,
  output logic [NUM_BIDIR-1:0] bidir_cs,
  output logic [NUM_BIDIR-1:0] bidir_sl,
  output logic [NUM_BIDIR-1:0] bidir_pu,
  output logic [NUM_BIDIR-1:0] bidir_pd,
  output logic [NUM_INPUT-1:0] input_pu,
  output logic [NUM_INPUT-1:0] input_pd
);

  localparam int NUM_PADS = NUM_BIDIR + NUM_INPUT;
  localparam int CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);

  seq_state_e       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [CFG_W-1:0]  data_reg;
  logic              err_reg, err_next;
  logic              accept, apply_en, addr_bad, need_break;
  logic [NUM_BIDIR-1:0] brk_vec;
  pad_mode_e         mode_vec [NUM_BIDIR];
  pad_mode_e         new_mode;

  assign addr_bad   = (cfg_addr >= ADDR_W'(NUM_PADS));
  assign new_mode   = pad_mode_e'(cfg_data[MODE_LSB +: 2]);
  assign need_break = |brk_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      addr_reg  <= '0;
      data_reg  <= RESET_CFG;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
      if (accept) begin
        addr_reg <= cfg_addr;
        data_reg <= sanitize_cfg(cfg_data);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept && !addr_bad) begin
          if (need_break) begin
            state_next = ST_SETTLE;
            cnt_next   = CNT_INIT;
          end else begin
            state_next = ST_APPLY;
          end
        end
      end
      ST_SETTLE: begin
        if (cnt_reg == '0) state_next = ST_APPLY;
        else               cnt_next   = cnt_reg - 1'b1;
      end
      ST_APPLY: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = (state_reg == ST_IDLE);
    busy      = ~cfg_ready;
    accept    = cfg_valid && cfg_ready;
    apply_en  = (state_reg == ST_APPLY);
    err       = err_reg;
    // A new error in the same cycle as err_clr keeps err high.
    if (accept && (addr_bad || (cfg_data[PU_BIT] && cfg_data[PD_BIT]))) err_next = 1'b1;
    else if (err_clr) err_next = 1'b0;
    else              err_next = err_reg;
  end

  for (genvar gi = 0; gi < NUM_BIDIR; gi++) begin : g_bidir
    localparam logic [ADDR_W-1:0] SLOT_ADDR = ADDR_W'(gi);

    assign brk_vec[gi] = (cfg_addr == SLOT_ADDR) && mode_drives(mode_vec[gi])
                         && (new_mode != mode_vec[gi]);

    pad_cfg_slot u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (apply_en && (addr_reg == SLOT_ADDR)),
      .wr_cfg    (data_reg),
      .force_set (accept && brk_vec[gi]),
      .func_out  (func_out[gi]),
      .func_oe   (func_oe[gi]),
      .mode      (mode_vec[gi]),
      .pad_out   (bidir_out[gi]),
      .pad_oe    (bidir_oe[gi]),
      .pad_ie    (bidir_ie[gi]),
      .pad_cs    (bidir_cs[gi]),
      .pad_sl    (bidir_sl[gi]),
      .pad_pu    (bidir_pu[gi]),
      .pad_pd    (bidir_pd[gi])
    );
  end

  for (genvar gi = 0; gi < NUM_INPUT; gi++) begin : g_input
    localparam logic [ADDR_W-1:0] SLOT_ADDR = ADDR_W'(NUM_BIDIR + gi);
    logic pu_reg, pd_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pu_reg <= 1'b0;
        pd_reg <= 1'b0;
      end else if (apply_en && (addr_reg == SLOT_ADDR)) begin
        pu_reg <= data_reg[PU_BIT];
        pd_reg <= data_reg[PD_BIT];
      end
    end

    assign input_pu[gi] = pu_reg;
    assign input_pd[gi] = pd_reg;
  end

endmodule

// File: tb/tb_pad_cfg_sequencer.sv
// Randomized and directed bench for pad_cfg_sequencer against a latency-based behavioural model.
module tb_pad_cfg_sequencer;
  localparam int NI = 12;
  localparam int NB = 42;
  localparam int SC = 4;
  localparam int NP = NI + NB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [5:0]    cfg_addr = '0;
  logic [5:0]    cfg_data = '0;
  logic          busy, err;
  logic          err_clr = 1'b0;
  logic [NB-1:0] func_out = '0, func_oe = '0;
  logic [NB-1:0] bidir_out, bidir_oe, bidir_ie, bidir_cs, bidir_sl, bidir_pu, bidir_pd;
  logic [NI-1:0] input_pu, input_pd;

  always #5 clk = ~clk;

  pad_cfg_sequencer #(.NUM_INPUT(NI), .NUM_BIDIR(NB), .SETTLE_CYCLES(SC)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .busy(busy), .err(err), .err_clr(err_clr),
    .func_out(func_out), .func_oe(func_oe), .bidir_out(bidir_out), .bidir_oe(bidir_oe),
    .bidir_ie(bidir_ie), .bidir_cs(bidir_cs), .bidir_sl(bidir_sl), .bidir_pu(bidir_pu),
    .bidir_pd(bidir_pd), .input_pu(input_pu), .input_pd(input_pd)
  );

  int checks = 0;
  int errors = 0;

  // Model: per-pad config plus "cycles until the pending write lands".
  int       mode_m [NB];
  bit       cs_m [NB], sl_m [NB], pu_m [NB], pd_m [NB];
  bit       ipu_m [NI], ipd_m [NI];
  int       remaining;
  int       force_idx;
  int       pend_addr;
  bit [5:0] pend_data;
  bit       err_m;
  bit       check_en = 1'b0;
  bit       hold_oe7 = 1'b0;

  task automatic check_vec(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NB; i++) begin
      mode_m[i] = 1; cs_m[i] = 0; sl_m[i] = 0; pu_m[i] = 0; pd_m[i] = 0;
    end
    for (int i = 0; i < NI; i++) begin
      ipu_m[i] = 0; ipd_m[i] = 0;
    end
    remaining = 0; force_idx = -1; pend_addr = 0; pend_data = '0; err_m = 0;
  endfunction

  function automatic void model_edge();
    bit acc, bad, brk;
    bit [5:0] d;
    int a;
    if (!rst_n) return;
    acc = 0; bad = 0;
    if (remaining > 0) begin
      remaining--;
      if (remaining == 0) begin
        if (pend_addr < NB) begin
          mode_m[pend_addr] = int'(pend_data[5:4]);
          cs_m[pend_addr] = pend_data[3]; sl_m[pend_addr] = pend_data[2];
          pu_m[pend_addr] = pend_data[1]; pd_m[pend_addr] = pend_data[0];
        end else begin
          ipu_m[pend_addr-NB] = pend_data[1];
          ipd_m[pend_addr-NB] = pend_data[0];
        end
        force_idx = -1;
      end
    end else if (cfg_valid) begin
      acc = 1;
      a = int'(cfg_addr);
      bad = (a >= NP);
      if (!bad) begin
        d = cfg_data;
        if (d[1] && d[0]) d[1:0] = 2'b00;
        brk = (a < NB) && (mode_m[a] >= 2) && (int'(d[5:4]) != mode_m[a]);
        pend_addr = a; pend_data = d;
        remaining = brk ? SC + 1 : 1;
        force_idx = brk ? a : -1;
      end
    end
    if (acc && (bad || (cfg_data[1] && cfg_data[0]))) err_m = 1;
    else if (err_clr) err_m = 0;
  endfunction

  always @(negedge clk) begin
    logic [NB-1:0] e_out, e_oe, e_ie, e_cs, e_sl, e_pu, e_pd;
    logic [NI-1:0] e_ipu, e_ipd;
    if (check_en) begin
      for (int i = 0; i < NB; i++) begin
        e_out[i] = (mode_m[i] >= 2) ? func_out[i] : 1'b0;
        e_oe[i]  = (force_idx == i) ? 1'b0 : (mode_m[i] == 2) ? 1'b1 :
                   (mode_m[i] == 3) ? func_oe[i] : 1'b0;
        e_ie[i]  = (mode_m[i] != 0);
        e_cs[i] = cs_m[i]; e_sl[i] = sl_m[i]; e_pu[i] = pu_m[i]; e_pd[i] = pd_m[i];
      end
      for (int i = 0; i < NI; i++) begin
        e_ipu[i] = ipu_m[i]; e_ipd[i] = ipd_m[i];
      end
      check_vec("bidir_out", 64'(bidir_out), 64'(e_out));
      check_vec("bidir_oe", 64'(bidir_oe), 64'(e_oe));
      check_vec("bidir_ie", 64'(bidir_ie), 64'(e_ie));
      check_vec("bidir_cs", 64'(bidir_cs), 64'(e_cs));
      check_vec("bidir_sl", 64'(bidir_sl), 64'(e_sl));
      check_vec("bidir_pu", 64'(bidir_pu), 64'(e_pu));
      check_vec("bidir_pd", 64'(bidir_pd), 64'(e_pd));
      check_vec("input_pu", 64'(input_pu), 64'(e_ipu));
      check_vec("input_pd", 64'(input_pd), 64'(e_ipd));
      check_vec("cfg_ready", 64'(cfg_ready), 64'(remaining == 0));
      check_vec("busy", 64'(busy), 64'(remaining != 0));
      check_vec("err", 64'(err), 64'(err_m));
    end
  end

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    cfg_valid = 1'b0;
    err_clr   = 1'b0;
    func_out  = NB'({$urandom(), $urandom()});
    func_oe   = NB'({$urandom(), $urandom()});
    if (hold_oe7) func_oe[7] = 1'b1;
  endtask

  task automatic write(input int addr, input logic [5:0] data, input bit clr);
    int n = 0;
    bit acc = 0;
    while (!acc && n < 100) begin
      cfg_valid = 1'b1; cfg_addr = 6'(addr); cfg_data = data; err_clr = clr;
      acc = (remaining == 0);
      tick();
      n++;
    end
    check_vec("accept_timeout", 64'(acc), 64'(1));
    $display("write addr=%0d data=%b clr=%0d waited=%0d", addr, data, clr, n - 1);
  endtask

  // Counts busy cycles after an accept; offers a competing write while busy.
  task automatic count_busy(input int pad, output int n);
    n = 0;
    @(negedge clk);
    while (cfg_ready !== 1'b1 && n < 40) begin
      n++;
      if (pad >= 0) check_vec("forced_oe", 64'(bidir_oe[pad]), 64'(0));
      cfg_valid = 1'b1; cfg_addr = 6'd5; cfg_data = 6'b11_0000;
      tick();
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    int a;
    model_reset();
    check_en = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    @(negedge clk);
    check_vec("rst_oe", 64'(bidir_oe), 64'(0));
    check_vec("rst_ie", 64'(bidir_ie), {22'd0, {NB{1'b1}}});
    check_vec("rst_ready", 64'(cfg_ready), 64'(1));
    check_vec("rst_err", 64'(err), 64'(0));

    // INPUT -> OUTPUT, no break
    write(3, 6'b10_0000, 0);
    @(negedge clk);
    check_vec("p3_oe_t0", 64'(bidir_oe[3]), 64'(0));
    tick();
    @(negedge clk);
    check_vec("p3_oe_t1", 64'(bidir_oe[3]), 64'(1));
    check_vec("p3_ready", 64'(cfg_ready), 64'(1));

    // OUTPUT -> INPUT with settle window
    write(3, 6'b01_0000, 0);
    count_busy(3, n);
    check_vec("p3_busy_cycles", 64'(n), 64'(5));
    check_vec("p3_oe_after", 64'(bidir_oe[3]), 64'(0));

    // BIDIR follows func_oe, then BIDIR -> HIZ with func_oe held high
    write(7, 6'b11_0000, 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      func_oe[7] = k[0];
      @(negedge clk);
      check_vec("p7_follow", 64'(bidir_oe[7]), 64'(k[0]));
    end
    hold_oe7 = 1'b1;
    tick();
    write(7, 6'b00_0000, 0);
    count_busy(7, n);
    check_vec("p7_busy_cycles", 64'(n), 64'(5));
    check_vec("p7_ie_hiz", 64'(bidir_ie[7]), 64'(0));
    hold_oe7 = 1'b0;

    // Error handling
    write(60, 6'b10_0000, 0);
    @(negedge clk);
    check_vec("err_badaddr", 64'(err), 64'(1));
    write(44, 6'b01_0011, 0);
    tick();
    @(negedge clk);
    check_vec("in2_pu", 64'(input_pu[2]), 64'(0));
    check_vec("in2_pd", 64'(input_pd[2]), 64'(0));
    check_vec("err_sticky", 64'(err), 64'(1));
    write(6, 6'b10_0000, 1);
    @(negedge clk);
    check_vec("err_cleared", 64'(err), 64'(0));
    write(61, 6'b00_0000, 1);
    @(negedge clk);
    check_vec("err_set_wins", 64'(err), 64'(1));

    // Reset during settle (cnt==2): pending HIZ write must be dropped
    write(9, 6'b10_0000, 0);
    tick();
    write(9, 6'b00_0000, 0);
    tick();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    check_vec("mid_rst_ready", 64'(cfg_ready), 64'(1));
    check_vec("mid_rst_oe", 64'(bidir_oe), 64'(0));
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check_vec("p9_ie_kept", 64'(bidir_ie[9]), 64'(1));
    check_vec("p9_ready", 64'(cfg_ready), 64'(1));

    // Random traffic
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 7))
        0:       a = $urandom_range(NP, 63);
        1, 2, 3: a = $urandom_range(0, 5);
        default: a = $urandom_range(0, NP - 1);
      endcase
      write(a, 6'($urandom()), ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 3)) tick();
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1;
      end
    end

    repeat (10) tick();
    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
